// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies 160 bytes from page {src,0x00} into OAM and
// arbitrates the external bus between the DMA engine and the CPU.
module oam_dma_ctrl (
  input  logic        clk,
  input  logic        nreset,
  input  logic [1:0]  tcyc,
  input  logic [15:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic [15:0] ext_adr,
  output logic        ext_rd,
  output logic        ext_wr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic [7:0]  io_adr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [7:0]  io_dout,
  input  logic [7:0]  io_din,
  output logic [7:0]  oam_adr,
  output logic        oam_wr,
  output logic [7:0]  oam_dout,
  output logic        dma_active
);

  localparam int unsigned LAST_IDX = 159;
  localparam logic [15:0] DMA_REG  = 16'hFF46;

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_src;
  logic [7:0]  r_idx;
  logic [7:0]  r_latch;
  logic [7:0]  w_eff_src;
  logic        w_reg_sel;
  logic        w_io_sel;
  logic        w_ext_sel;
  logic        w_commit;
  logic        w_xfer;
  logic        w_last;

  assign w_reg_sel = (cpu_adr == DMA_REG);
  assign w_io_sel  = (cpu_adr[15:8] == 8'hFF) && !w_reg_sel;
  assign w_ext_sel = (cpu_adr[15:8] != 8'hFF);
  assign w_commit  = cpu_wr && w_reg_sel && (tcyc == 2'd3);
  assign w_xfer    = (r_state == S_XFER);
  assign w_last    = (r_idx == 8'(LAST_IDX));
  // Sources in echo RAM 0xE0-0xFF fold back onto work RAM.
  assign w_eff_src = (r_src >= 8'hE0) ? (r_src - 8'h20) : r_src;
  assign dma_active = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_src   <= 8'h00;
      r_idx   <= 8'h00;
      r_latch <= 8'h00;
    end else begin
      if (w_commit) r_src <= cpu_dout;
      if (w_xfer && (tcyc == 2'd2)) r_latch <= ext_din;
      if (w_commit)                          r_idx <= 8'h00;
      else if (w_xfer && (tcyc == 2'd3))     r_idx <= w_last ? 8'h00 : (r_idx + 8'd1);
    end
  end

  // Next-state and bus routing; everything is forced quiet while in reset.
  always_comb begin
    w_state_nxt = r_state;
    ext_adr     = cpu_adr;
    ext_rd      = 1'b0;
    ext_wr      = 1'b0;
    ext_dout    = 8'h00;
    io_adr      = cpu_adr[7:0];
    io_rd       = 1'b0;
    io_wr       = 1'b0;
    io_dout     = cpu_dout;
    oam_adr     = r_idx;
    oam_wr      = 1'b0;
    oam_dout    = r_latch;
    cpu_din     = 8'hFF;

    case (r_state)
      S_IDLE:  w_state_nxt = S_IDLE;
      S_START: if (tcyc == 2'd3) w_state_nxt = S_XFER;
      S_XFER:  if ((tcyc == 2'd3) && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_commit) w_state_nxt = S_START;

    if (nreset) begin
      io_rd = cpu_rd && w_io_sel;
      io_wr = cpu_wr && w_io_sel;
      if (w_xfer) begin
        ext_adr = {w_eff_src, r_idx};
        ext_rd  = 1'b1;
        oam_wr  = (tcyc == 2'd3);
      end else begin
        ext_rd   = cpu_rd && w_ext_sel;
        ext_wr   = cpu_wr && w_ext_sel;
        ext_dout = cpu_dout;
      end
      if (w_reg_sel)     cpu_din = r_src;
      else if (w_io_sel) cpu_din = io_din;
      else if (!w_xfer)  cpu_din = ext_din;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl against a transfer-progress reference model.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic [1:0]  tcyc = 2'd3;
  logic [15:0] cpu_adr = 16'h0000;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = 8'h00;
  logic [7:0]  cpu_din;
  logic [15:0] ext_adr;
  logic        ext_rd, ext_wr;
  logic [7:0]  ext_dout;
  logic [7:0]  ext_din = 8'h00;
  logic [7:0]  io_adr;
  logic        io_rd, io_wr;
  logic [7:0]  io_dout;
  logic [7:0]  io_din = 8'h00;
  logic [7:0]  oam_adr;
  logic        oam_wr;
  logic [7:0]  oam_dout;
  logic        dma_active;

  int total = 0;
  int bad   = 0;

  // Model: the M-cycle number of the last commit fixes the whole transfer timeline.
  int         m_cnt    = 0;
  int         m_commit = -1;
  logic [7:0] m_src    = 8'h00;
  logic [7:0] m_latch  = 8'h00;

  oam_dma_ctrl dut (
    .clk(clk), .nreset(nreset), .tcyc(tcyc),
    .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din),
    .ext_adr(ext_adr), .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_dout(ext_dout),
    .ext_din(ext_din),
    .io_adr(io_adr), .io_rd(io_rd), .io_wr(io_wr), .io_dout(io_dout), .io_din(io_din),
    .oam_adr(oam_adr), .oam_wr(oam_wr), .oam_dout(oam_dout),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s m=%0d t=%0d got=%h exp=%h", tag, m_cnt, tcyc, got, exp);
    end
  endtask

  // One M-cycle with the CPU strobes held; nreset low from T-cycle rst_t onward (4 = never).
  task automatic run_m(input logic [15:0] adr, input logic rd, input logic wr,
                       input logic [7:0] dout, input int rst_t);
    int   phase;
    logic xfer, act, reg_sel, io_sel, ext_sel;
    logic [7:0]  idx, eff;
    logic [15:0] e_adr;
    logic [7:0]  e_din;
    phase = (m_commit < 0) ? 0 : (m_cnt - m_commit);
    if (phase > 161) begin
      m_commit = -1;
      phase = 0;
    end
    for (int t = 0; t < 4; t++) begin
      @(posedge clk);
      #1;
      tcyc     = 2'(t);
      cpu_adr  = adr;
      cpu_rd   = rd;
      cpu_wr   = wr;
      cpu_dout = dout;
      ext_din  = 8'($urandom);
      io_din   = 8'($urandom);
      nreset   = (t >= rst_t) ? 1'b0 : 1'b1;
      if (!nreset) begin
        m_commit = -1;
        m_src    = 8'h00;
        m_latch  = 8'h00;
        phase    = 0;
      end
      @(negedge clk);
      xfer    = (phase >= 2) && (phase <= 161);
      act     = (phase >= 1) && (phase <= 161);
      idx     = 8'(phase - 2);
      eff     = (m_src >= 8'hE0) ? (m_src - 8'h20) : m_src;
      reg_sel = (adr == 16'hFF46);
      io_sel  = (adr >= 16'hFF00) && !reg_sel;
      ext_sel = (adr < 16'hFF00);
      if (!nreset) begin
        chk("rst_ext_rd", 32'(ext_rd), 0);
        chk("rst_ext_wr", 32'(ext_wr), 0);
        chk("rst_io_rd",  32'(io_rd), 0);
        chk("rst_io_wr",  32'(io_wr), 0);
        chk("rst_oam_wr", 32'(oam_wr), 0);
        chk("rst_ext_adr", 32'(ext_adr), 32'(adr));
        chk("rst_ext_dout", 32'(ext_dout), 0);
        chk("rst_oam_dout", 32'(oam_dout), 0);
        chk("rst_cpu_din", 32'(cpu_din), 32'hFF);
        chk("rst_active", 32'(dma_active), 0);
      end else begin
        e_adr = xfer ? {eff, idx} : adr;
        if (reg_sel)     e_din = m_src;
        else if (io_sel) e_din = io_din;
        else if (xfer)   e_din = 8'hFF;
        else             e_din = ext_din;
        chk("dma_active", 32'(dma_active), 32'(act));
        chk("ext_adr", 32'(ext_adr), 32'(e_adr));
        chk("ext_rd", 32'(ext_rd), 32'(xfer ? 1'b1 : (rd && ext_sel)));
        chk("ext_wr", 32'(ext_wr), 32'(!xfer && wr && ext_sel));
        if (!xfer) chk("ext_dout", 32'(ext_dout), 32'(dout));
        chk("io_rd", 32'(io_rd), 32'(rd && io_sel));
        chk("io_wr", 32'(io_wr), 32'(wr && io_sel));
        chk("io_adr", 32'(io_adr), 32'(adr[7:0]));
        chk("io_dout", 32'(io_dout), 32'(dout));
        chk("oam_wr", 32'(oam_wr), 32'(xfer && (t == 3)));
        if (xfer && (t == 3)) begin
          chk("oam_adr", 32'(oam_adr), 32'(idx));
          chk("oam_dout", 32'(oam_dout), 32'(m_latch));
        end
        chk("cpu_din", 32'(cpu_din), 32'(e_din));
        if (xfer && (t == 2)) m_latch = ext_din;
        if ((t == 3) && wr && reg_sel) begin
          m_src    = dout;
          m_commit = m_cnt;
        end
      end
    end
    m_cnt++;
  endtask

  // Random CPU traffic that never touches the DMA register with a write.
  task automatic bg();
    int          cls;
    logic [15:0] a;
    logic        r, w;
    cls = int'($urandom_range(0, 3));
    r = 1'b0;
    w = 1'b0;
    case (cls)
      0: a = 16'($urandom_range(0, 16'hFEFF));
      1: begin
        a = 16'hFF00 | 16'($urandom_range(0, 255));
        if (a == 16'hFF46) a = 16'hFF80;
      end
      2: a = 16'hFF46;
      default: a = 16'($urandom);
    endcase
    if (cls == 3 || a == 16'hFF46) r = ($urandom_range(0, 1) == 1);
    else if ($urandom_range(0, 1) == 1) r = 1'b1;
    else w = 1'b1;
    run_m(a, r, w, 8'($urandom), 4);
  endtask

  task automatic dma_write(input logic [7:0] src);
    run_m(16'hFF46, 1'b0, 1'b1, src, 4);
  endtask

  initial begin
    run_m(16'h1234, 1'b1, 1'b0, 8'h00, 0);
    run_m(16'hFF80, 1'b0, 1'b1, 8'h11, 0);
    run_m(16'hC000, 1'b0, 1'b1, 8'h5A, 4);
    run_m(16'hFF46, 1'b1, 1'b0, 8'h00, 4);

    dma_write(8'hC1);
    for (int i = 1; i <= 165; i++) begin
      if (i == 10)      run_m(16'h8000, 1'b1, 1'b0, 8'h00, 4);
      else if (i == 11) run_m(16'hC000, 1'b0, 1'b1, 8'hA5, 4);
      else if (i == 12) run_m(16'hFF80, 1'b1, 1'b0, 8'h00, 4);
      else              bg();
    end

    dma_write(8'hF3);
    for (int i = 1; i <= 163; i++) begin
      if (i == 30) run_m(16'hFF46, 1'b1, 1'b0, 8'h00, 4);
      else         bg();
    end

    dma_write(8'hC0);
    for (int i = 1; i <= 51; i++) bg();
    dma_write(8'hC2);
    for (int i = 1; i <= 164; i++) bg();

    dma_write(8'hC5);
    for (int i = 1; i <= 81; i++) bg();
    run_m(16'h4000, 1'b1, 1'b0, 8'h00, 1);
    run_m(16'hFF46, 1'b1, 1'b0, 8'h00, 4);
    run_m(16'hC000, 1'b0, 1'b1, 8'h5A, 4);
    for (int i = 0; i < 8; i++) bg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

OAM DMA controller and bus arbiter between the CPU core and the external memory bus. On a CPU write to register 0xFF46, it copies 160 bytes from page {src,0x00} to OAM, one byte per M-cycle. While the copy runs it owns the external bus and blocks CPU accesses below 0xFF00. CPU accesses to 0xFF00–0xFFFF (IO/HRAM) always pass through on a separate port.

## Interface
- No parameters.
- clk  in  1  system clock; one T-cycle per clk.
- nreset  in  1  asynchronous, active-low reset.
- tcyc  in  2  T-cycle index within the current M-cycle (0=T1 … 3=T4); advances every clk.
- cpu_adr  in  16  CPU address.
- cpu_rd, cpu_wr  in  1  CPU read/write strobes, held for the whole M-cycle.
- cpu_dout  in  8  CPU write data.
- cpu_din  out  8  read data returned to the CPU.
- ext_adr  out  16  external bus address (0x0000–0xFEFF space).
- ext_rd, ext_wr  out  1  external bus strobes.
- ext_dout  out  8  external write data.
- ext_din  in  8  external read data.
- io_adr  out  8  low byte of the IO/HRAM address.
- io_rd, io_wr  out  1  IO/HRAM strobes.
- io_dout  out  8  IO/HRAM write data.
- io_din  in  8  IO/HRAM read data.
- oam_adr  out  8  OAM byte index (0–159).
- oam_wr  out  1  OAM write strobe.
- oam_dout  out  8  OAM write data.
- dma_active  out  1  high in START and XFER.

## Operation
- Register dma_src[7:0] resets to 0x00.
- A CPU write to 0xFF46 is committed at tcyc==3. It loads dma_src from cpu_dout, clears idx, and enters START.
- A CPU read of 0xFF46 returns dma_src. This register is never forwarded to the io port.
- States:
  - IDLE: no DMA. Leave only on a 0xFF46 commit.
  - START: one full M-cycle of delay. The bus is still given to the CPU. Enter XFER at the next tcyc==0.
  - XFER: DMA owns the external bus.
- XFER, per M-cycle:
  - ext_adr = {eff_src, idx}, where eff_src = dma_src − 0x20 if dma_src ≥ 0xE0, else dma_src.
  - ext_rd is high for all 4 T-cycles.
  - ext_din is latched at the end of tcyc==2.
  - oam_wr=1 and oam_adr=idx during tcyc==3; oam_dout is the latched byte.
  - idx increments at the end of tcyc==3.
  - After the write with idx==159, go to IDLE.
- CPU routing, IDLE/START: cpu_adr < 0xFF00 passes to the ext port. ext_adr, ext_rd, ext_wr and ext_dout follow the CPU; cpu_din = ext_din.
- CPU routing, all states: cpu_adr ≥ 0xFF00 (except 0xFF46) passes to the io port; cpu_din = io_din.
- CPU routing, XFER, cpu_adr < 0xFF00:
  - Writes are dropped; ext_wr stays low.
  - Reads return 0xFF.
- Restart: a 0xFF46 commit in START or XFER loads the new dma_src, clears idx, and re-enters START. oam_wr in that same tcyc==3 still completes for the old transfer.
- Reset mid-transfer: the transfer aborts immediately.
- Outputs are combinational from state, tcyc and the CPU inputs; no added CPU latency.

## Timing
- Reset values: state=IDLE, idx=0, dma_src=0x00, latch=0x00, dma_active=0.
- While in reset:
  - ext_rd, ext_wr, io_rd, io_wr and oam_wr are 0.
  - ext_adr passes cpu_adr; ext_dout and oam_dout are 0.
  - cpu_din = 0xFF.
- Latency: commit at M-cycle N T4; START for M-cycle N+1; the first OAM write at M-cycle N+2 T4; the last (idx 159) at M-cycle N+161 T4.
- dma_active rises on the clk edge after the commit. It falls on the edge ending N+161 T4.
- Total transfer: 160 M-cycles = 640 clk.
- idx is 8 bits and never exceeds 159. No wrap.
- tcyc must increment by 1 mod 4 each clk. Behaviour with a non-monotonic tcyc is undefined.

## Test plan
- Write 0xC1 to 0xFF46 at M-cycle 0 T4:
  - M1 has no DMA bus ownership.
  - M2 shows ext_adr=0xC100, ext_rd=1.
  - M2 T4: oam_wr=1, oam_adr=0, oam_dout=ext_din.
  - M161 T4: oam_adr=159. dma_active falls after it.
- During XFER:
  - CPU read 0x8000 returns 0xFF with ext_adr still the DMA address.
  - CPU write 0xC000 leaves ext_wr=0.
  - CPU read 0xFF80 returns io_din with io_rd=1.
- Write 0xF3 to 0xFF46: source addresses are 0xD300–0xD39F. A CPU read of 0xFF46 returns 0xF3.
- Restart: write 0xC0, then at idx==50 write 0xC2:
  - one START M-cycle follows;
  - the next transfer starts at 0xC200, oam_adr=0;
  - 160 more writes.
- Deassert nreset mid-XFER at idx==80: all strobes drop immediately, dma_active=0, dma_src=0x00.
- IDLE pass-through: CPU write 0x5A to 0xC000 gives ext_wr=1, ext_adr=0xC000, ext_dout=0x5A, with no io or oam strobes.
